// File: rtl/risc8_io_if.sv
`default_nettype none
// ============================================================================
// Module      : risc8_io_if
// Description : risc8 core data-bus signals as seen by an IO-space slave.
// Revision    : 1.0  initial release
// ============================================================================
interface risc8_io_if;
    logic [15:0] addr;
    logic        wen;
    logic        ren;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        io_sel;

    modport master (output addr, wen, ren, wdata, input  rdata, io_sel);
    modport slave  (input  addr, wen, ren, wdata, output rdata, io_sel);
endinterface
`default_nettype wire

// File: rtl/risc8_io.sv
`default_nettype none
// ============================================================================
// Module      : risc8_io
// Description : IO-space slave for risc8: N GPIO ports plus a prescaled
//               16-bit timer with compare, CTC and IRQ. Registered reads.
// Revision    : 1.0  initial release
// ============================================================================
module risc8_io #(
    parameter int          NPORTS      = 1,
    parameter logic [6:0]  PORT_BASE   = 7'h36,
    parameter logic [6:0]  TMR_BASE    = 7'h4C,
    parameter logic [15:0] IO_LIMIT    = 16'h60,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    risc8_io_if.slave           bus,
    input  logic [8*NPORTS-1:0] pin_in,
    output logic [8*NPORTS-1:0] port_out,
    output logic [8*NPORTS-1:0] ddr_out,
    output logic                irq
);
    localparam int c_W = 8 * NPORTS;

    function automatic logic [6:0] port_addr(input int k, input int off);
        return 7'(int'(PORT_BASE) - 3 * k + off);
    endfunction

    logic           w_io, w_wr, w_rd, w_tmr;
    logic [6:0]     w_a, w_toff;
    logic [7:0]     w_rdata;
    logic [c_W-1:0] w_pin;
    logic [9:0]     w_div_m1;
    logic           w_run, w_tick, w_match, w_cmp_set, w_tov_set;
    logic [1:0]     w_clr;

    logic [c_W-1:0] r_sync [SYNC_STAGES];
    logic [c_W-1:0] r_port, r_ddr;
    logic [15:0]    r_tcnt, r_ocr;
    logic [7:0]     r_temp, r_timsk, r_rdata;
    logic [3:0]     r_tccr;
    logic [1:0]     r_tifr;
    logic [9:0]     r_presc;
    logic           r_io_sel, r_irq;

    assign w_io   = bus.addr < IO_LIMIT;
    assign w_wr   = bus.wen & w_io;
    assign w_rd   = bus.ren & w_io;
    assign w_a    = bus.addr[6:0];
    assign w_toff = w_a - TMR_BASE;
    assign w_tmr  = (w_a >= TMR_BASE) && (w_toff < 7'd7);
    assign w_pin  = r_sync[SYNC_STAGES-1];

    function automatic logic tw(input logic [6:0] off);
        return w_wr && w_tmr && (w_toff == off);
    endfunction

    always_comb begin
        w_run = 1'b1;
        case (r_tccr[2:0])
            3'd1:    w_div_m1 = 10'd0;
            3'd2:    w_div_m1 = 10'd7;
            3'd3:    w_div_m1 = 10'd63;
            3'd4:    w_div_m1 = 10'd255;
            3'd5:    w_div_m1 = 10'd1023;
            default: begin
                w_div_m1 = 10'd0;
                w_run    = 1'b0;
            end
        endcase
    end

    // A CPU commit to TCNT suppresses the tick and its compare/overflow effects.
    assign w_tick    = w_run && (r_presc == w_div_m1) && !tw(7'd0);
    assign w_match   = r_tcnt == r_ocr;
    assign w_cmp_set = w_tick && w_match;
    assign w_tov_set = w_tick && (r_tcnt == 16'hFFFF) && !(w_match && r_tccr[3]);
    assign w_clr     = tw(7'd5) ? bus.wdata[1:0] : 2'b00;

    always_comb begin
        w_rdata = 8'h00;
        for (int k = 0; k < NPORTS; k++) begin
            if (w_a == port_addr(k, 0)) w_rdata = w_pin[8*k +: 8];
            if (w_a == port_addr(k, 1)) w_rdata = r_ddr[8*k +: 8];
            if (w_a == port_addr(k, 2)) w_rdata = r_port[8*k +: 8];
        end
        if (w_tmr) begin
            case (w_toff[2:0])
                3'd0:    w_rdata = r_tcnt[7:0];
                3'd1:    w_rdata = r_temp;
                3'd2:    w_rdata = r_ocr[7:0];
                3'd3:    w_rdata = r_ocr[15:8];
                3'd4:    w_rdata = {4'h0, r_tccr};
                3'd5:    w_rdata = {6'h00, r_tifr};
                3'd6:    w_rdata = r_timsk;
                default: w_rdata = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port <= '0;
            r_ddr  <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < NPORTS; k++) begin
                if (w_a == port_addr(k, 0)) r_port[8*k +: 8] <= r_port[8*k +: 8] ^ bus.wdata;
                if (w_a == port_addr(k, 1)) r_ddr[8*k +: 8]  <= bus.wdata;
                if (w_a == port_addr(k, 2)) r_port[8*k +: 8] <= bus.wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt   <= 16'h0000;
            r_ocr    <= 16'hFFFF;
            r_tccr   <= 4'h0;
            r_tifr   <= 2'b00;
            r_timsk  <= 8'h00;
            r_temp   <= 8'h00;
            r_presc  <= 10'd0;
            r_irq    <= 1'b0;
            r_rdata  <= 8'h00;
            r_io_sel <= 1'b0;
        end else begin
            r_io_sel <= (bus.wen | bus.ren) & w_io;
            if (w_rd) r_rdata <= w_rdata;

            if (tw(7'd1) || tw(7'd3))              r_temp <= bus.wdata;
            else if (w_rd && w_tmr && w_toff == 7'd0) r_temp <= r_tcnt[15:8];

            if (tw(7'd0))    r_tcnt <= {r_temp, bus.wdata};
            else if (w_tick) r_tcnt <= (w_match && r_tccr[3]) ? 16'h0000 : r_tcnt + 16'd1;

            if (tw(7'd2)) r_ocr   <= {r_temp, bus.wdata};
            if (tw(7'd4)) r_tccr  <= bus.wdata[3:0];
            if (tw(7'd6)) r_timsk <= bus.wdata;

            if (tw(7'd4))    r_presc <= 10'd0;
            else if (w_run)  r_presc <= (r_presc == w_div_m1) ? 10'd0 : r_presc + 10'd1;

            r_tifr <= (r_tifr & ~w_clr) | {w_cmp_set, w_tov_set};
            r_irq  <= |(r_tifr & r_timsk[1:0]);
        end
    end

    assign bus.rdata  = r_rdata;
    assign bus.io_sel = r_io_sel;
    assign port_out   = r_port;
    assign ddr_out    = r_ddr;
    assign irq        = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_risc8_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_risc8_io
// Description : Self-checking bench for risc8_io with two GPIO ports.
// Revision    : 1.0  initial release
// ============================================================================
module tb_risc8_io;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pin_in = 16'h0000;
    logic [15:0] port_out, ddr_out;
    logic        irq;
    int          total = 0;
    int          bad = 0;

    risc8_io_if bus_if ();

    risc8_io #(.NPORTS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .pin_in   (pin_in),
        .port_out (port_out),
        .ddr_out  (ddr_out),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_rd;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp_rd;
        bit          exp_sel;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_if.addr = a; bus_if.wdata = d; bus_if.wen = 1'b1;
        @(negedge clk);
        bus_if.wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic s);
        bus_if.addr = a; bus_if.ren = 1'b1;
        @(negedge clk);
        bus_if.ren = 1'b0;
        d = bus_if.rdata;
        s = bus_if.io_sel;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        logic       s;
        rd(a, d, s);
        chk(name, d, exp);
        chk({name, "_sel"}, s, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
    endtask

    // Reference model of the GPIO register file for the random phase.
    logic [7:0]  m_port [2];
    logic [7:0]  m_ddr  [2];
    logic [15:0] m_pin;

    function automatic logic [7:0] m_read(input logic [15:0] a);
        for (int k = 0; k < 2; k++) begin
            if (a == 16'(16'h36 - 3 * k)) return m_pin[8*k +: 8];
            if (a == 16'(16'h37 - 3 * k)) return m_ddr[k];
            if (a == 16'(16'h38 - 3 * k)) return m_port[k];
        end
        return 8'h00;
    endfunction

    task automatic m_write(input logic [15:0] a, input logic [7:0] d);
        for (int k = 0; k < 2; k++) begin
            if (a == 16'(16'h36 - 3 * k)) m_port[k] = m_port[k] ^ d;
            if (a == 16'(16'h37 - 3 * k)) m_ddr[k]  = d;
            if (a == 16'(16'h38 - 3 * k)) m_port[k] = d;
        end
    endtask

    initial begin
        logic [7:0]  d, lo, hi, m_rd;
        logic        s, io;
        logic [15:0] a;
        logic [15:0] alist [12];
        int          cnt;

        bus_if.addr = 16'h0; bus_if.wdata = 8'h0; bus_if.wen = 1'b0; bus_if.ren = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state and first read after release
        chk("rst_port", port_out, 16'h0000);
        chk("rst_ddr", ddr_out, 16'h0000);
        chk("rst_irq", irq, 1'b0);
        chk("rst_rdata", bus_if.rdata, 8'h00);
        chk("rst_iosel", bus_if.io_sel, 1'b0);
        rd_chk("rst_tcntl", 16'h004C, 8'h00);

        tbl[0]  = '{0, 16'h0038, 8'hA5, 8'h00, 1};
        tbl[1]  = '{0, 16'h0035, 8'h3C, 8'h00, 1};
        tbl[2]  = '{1, 16'h0038, 8'h00, 8'hA5, 1};
        tbl[3]  = '{1, 16'h0035, 8'h00, 8'h3C, 1};
        tbl[4]  = '{0, 16'h0036, 8'hFF, 8'h3C, 1};
        tbl[5]  = '{1, 16'h0038, 8'h00, 8'h5A, 1};
        tbl[6]  = '{0, 16'h0037, 8'h0F, 8'h5A, 1};
        tbl[7]  = '{1, 16'h0037, 8'h00, 8'h0F, 1};
        tbl[8]  = '{1, 16'h004E, 8'h00, 8'hFF, 1};
        tbl[9]  = '{1, 16'h004F, 8'h00, 8'hFF, 1};
        tbl[10] = '{1, 16'h0050, 8'h00, 8'h00, 1};
        tbl[11] = '{1, 16'h0040, 8'h00, 8'h00, 1};
        tbl[12] = '{1, 16'h0038, 8'h00, 8'h5A, 1};
        tbl[13] = '{0, 16'h0060, 8'h77, 8'h5A, 0};
        tbl[14] = '{1, 16'h0060, 8'h00, 8'h5A, 0};
        tbl[15] = '{0, 16'h00B8, 8'h11, 8'h5A, 0};
        tbl[16] = '{1, 16'h0038, 8'h00, 8'h5A, 1};
        tbl[17] = '{1, 16'h005F, 8'h00, 8'h00, 1};
        tbl[18] = '{0, 16'h0050, 8'hFF, 8'h00, 1};
        tbl[19] = '{1, 16'h0050, 8'h00, 8'h0F, 1};
        tbl[20] = '{0, 16'h0050, 8'h00, 8'h0F, 1};
        tbl[21] = '{1, 16'h0051, 8'h00, 8'h00, 1};

        for (int i = 0; i < 22; i++) begin
            if (tbl[i].is_rd) rd(tbl[i].a, d, s);
            else begin
                wr(tbl[i].a, tbl[i].d);
                d = bus_if.rdata;
                s = bus_if.io_sel;
            end
            chk($sformatf("tbl%0d_rdata", i), d, tbl[i].exp_rd);
            chk($sformatf("tbl%0d_iosel", i), s, tbl[i].exp_sel);
        end
        chk("tbl_port_out", port_out, 16'h3C5A);
        chk("tbl_ddr_out", ddr_out, 16'h000F);

        // Pin synchroniser latency
        pin_in = 16'h8100;
        rd_chk("pin_early", 16'h0033, 8'h00);
        idle(1);
        rd_chk("pin_late", 16'h0033, 8'h81);
        rd_chk("pin_p0", 16'h0036, 8'h00);

        // 16-bit TEMP access, /1 counting
        do_reset();
        wr(16'h004D, 8'h12);
        wr(16'h004C, 8'h34);
        wr(16'h0050, 8'h01);
        rd(16'h004C, lo, s);
        rd(16'h004D, hi, s);
        chk("tcnt_pair1", {hi, lo}, 16'h1234);
        wr(16'h0050, 8'h00);
        rd(16'h004C, lo, s);
        rd(16'h004D, hi, s);
        chk("tcnt_pair2", {hi, lo}, 16'h1237);

        // Asynchronous reset mid-run
        wr(16'h0052, 8'h03);
        wr(16'h0050, 8'h01);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_port", port_out, 16'h0000);
        chk("mid_rst_ddr", ddr_out, 16'h0000);
        chk("mid_rst_rdata", bus_if.rdata, 8'h00);
        chk("mid_rst_irq", irq, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        rd_chk("mid_rst_ocrl", 16'h004E, 8'hFF);
        rd_chk("mid_rst_ocrh", 16'h004F, 8'hFF);
        rd_chk("mid_rst_tcnt", 16'h004C, 8'h00);

        // Overflow FFFF->0000 with OCR=FFFF also matching
        wr(16'h0052, 8'h01);
        wr(16'h004D, 8'hFF);
        wr(16'h004C, 8'hFE);
        wr(16'h0050, 8'h01);
        idle(2);
        chk("tov_irq_pre", irq, 1'b0);
        idle(1);
        chk("tov_irq", irq, 1'b1);
        wr(16'h0050, 8'h00);
        rd_chk("tov_tifr", 16'h0051, 8'h03);
        wr(16'h0051, 8'h01);
        rd_chk("tov_clr_tifr", 16'h0051, 8'h02);
        chk("tov_clr_irq", irq, 1'b0);

        // CTC, /8, OCR=5: match every 6 ticks of 8 clocks
        do_reset();
        wr(16'h004F, 8'h00);
        wr(16'h004E, 8'h05);
        wr(16'h0052, 8'h02);
        wr(16'h0050, 8'h0A);
        cnt = 0;
        while (!irq && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("ctc_first_irq", cnt, 49);
        wr(16'h0051, 8'h02);
        idle(1);
        cnt += 2;
        chk("ctc_irq_clr", irq, 1'b0);
        while (!irq && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        chk("ctc_second_irq", cnt, 97);
        idle(300);
        rd_chk("ctc_no_tov", 16'h0051, 8'h02);
        rd(16'h004C, lo, s);
        rd(16'h004D, hi, s);
        chk("ctc_tcnt_range", ({hi, lo} <= 16'd5), 1'b1);

        // Flag set wins over a same-cycle clear
        do_reset();
        wr(16'h004F, 8'h00);
        wr(16'h004E, 8'h05);
        wr(16'h0050, 8'h09);
        idle(5);
        wr(16'h0051, 8'h02);
        rd_chk("set_wins", 16'h0051, 8'h02);
        wr(16'h0050, 8'h00);
        wr(16'h0051, 8'h02);
        rd_chk("clr_works", 16'h0051, 8'h00);

        // TCNT commit on a tick cycle: written value holds
        do_reset();
        wr(16'h0050, 8'h01);
        idle(3);
        wr(16'h004D, 8'h00);
        wr(16'h004C, 8'h50);
        rd(16'h004C, lo, s);
        rd(16'h004D, hi, s);
        chk("wr_beats_tick", {hi, lo}, 16'h0050);

        // Randomised GPIO traffic against the register-file model
        pin_in = 16'h0000;
        do_reset();
        idle(3);
        m_port = '{8'h00, 8'h00};
        m_ddr  = '{8'h00, 8'h00};
        m_pin  = 16'h0000;
        m_rd   = 8'h00;
        alist = '{16'h0033, 16'h0034, 16'h0035, 16'h0036, 16'h0037, 16'h0038,
                  16'h0000, 16'h0032, 16'h0039, 16'h005F, 16'h0060, 16'h00B8};
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 15) == 0) begin
                pin_in = 16'($urandom);
                m_pin  = pin_in;
                idle(3);
            end
            a  = alist[$urandom_range(0, 11)];
            io = a < 16'h0060;
            if ($urandom_range(0, 1) == 1) begin
                d = 8'($urandom);
                wr(a, d);
                if (io) m_write(a, d);
                chk("rnd_wr_sel", bus_if.io_sel, io);
            end else begin
                rd(a, d, s);
                if (io) m_rd = m_read(a);
                chk($sformatf("rnd_rd_%0h", a), d, m_rd);
                chk("rnd_rd_sel", s, io);
            end
            chk("rnd_port", port_out, {m_port[1], m_port[0]});
            chk("rnd_ddr", ddr_out, {m_ddr[1], m_ddr[0]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire
